// File: rtl/accel_display_sequencer.sv
// accel_display_sequencer: shows one accelerometer axis as sign plus BCD on six seg7 digit codes
module accel_display_sequencer #(
  parameter int DATA_W       = 10,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] x_data,
  input  logic [DATA_W-1:0] y_data,
  input  logic [DATA_W-1:0] z_data,
  input  logic              auto_en,
  input  logic              axis_next,
  output logic [23:0]       disp_codes,
  output logic              neg,
  output logic [1:0]        axis,
  output logic              disp_valid,
  output logic              busy
);
  localparam int CW  = $clog2(DATA_W + 1);
  localparam int DWW = $clog2(DWELL_CYCLES);
  typedef enum logic [1:0] {IDLE, LOAD, CONV, COMMIT} state_t;
  state_t            state;
  logic [DATA_W-1:0] sx, sy, sz, val, mag;
  logic [14:0]       bcd;
  logic [11:0]       adj;
  logic [CW-1:0]     cnt;
  logic [DWW-1:0]    dwell;
  logic [1:0]        sel, axis_r;
  logic              pend, neg_r, expire, adv, z3, z2, z1;
  logic [3:0]        d3;
  assign expire = auto_en && dwell == DWW'(DWELL_CYCLES - 1);
  assign adv    = axis_next || expire;
  assign val    = sel == 2'd0 ? sx : sel == 2'd1 ? sy : sz;
  assign busy   = state != IDLE;
  // The thousands digit never exceeds 4 for |value| <= 4096, so it needs no add-3 step.
  for (genvar i = 0; i < 3; i++) begin : g_adj
    assign adj[4*i+3:4*i] = bcd[4*i+3:4*i] >= 4'd5 ? bcd[4*i+3:4*i] + 4'd3 : bcd[4*i+3:4*i];
  end
  assign d3 = {1'b0, bcd[14:12]};
  assign z3 = d3 == 4'd0;
  assign z2 = z3 && bcd[11:8] == 4'd0;
  assign z1 = z2 && bcd[7:4] == 4'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sx         <= '0;
      sy         <= '0;
      sz         <= '0;
      mag        <= '0;
      bcd        <= '0;
      cnt        <= '0;
      dwell      <= '0;
      sel        <= 2'd0;
      axis_r     <= 2'd0;
      pend       <= 1'b0;
      neg_r      <= 1'b0;
      disp_codes <= 24'hFFFFFF;
      neg        <= 1'b0;
      axis       <= 2'd0;
      disp_valid <= 1'b0;
    end else begin
      disp_valid <= 1'b0;
      if (sample_valid) begin
        sx <= x_data;
        sy <= y_data;
        sz <= z_data;
      end
      dwell <= (!auto_en || adv) ? '0 : dwell + 1'b1;
      if (adv) sel <= sel == 2'd2 ? 2'd0 : sel + 2'd1;
      if (state == LOAD) pend <= 1'b0;
      if (sample_valid || adv) pend <= 1'b1;
      case (state)
        IDLE: if (pend) state <= LOAD;
        LOAD: begin
          neg_r  <= val[DATA_W-1];
          mag    <= val[DATA_W-1] ? -val : val;
          bcd    <= '0;
          cnt    <= CW'(DATA_W);
          axis_r <= sel;
          state  <= CONV;
        end
        CONV: begin
          bcd <= {bcd[13:12], adj, mag[DATA_W-1]};
          mag <= {mag[DATA_W-2:0], 1'b0};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= COMMIT;
        end
        default: begin
          disp_codes <= {4'hA + {2'b00, axis_r}, 4'hF, z3 ? 4'hF : d3, z2 ? 4'hF : bcd[11:8],
                         z1 ? 4'hF : bcd[7:4], bcd[3:0]};
          neg        <= neg_r;
          axis       <= axis_r;
          disp_valid <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_accel_display_sequencer.sv
// tb_accel_display_sequencer: directed and randomized checks against an arithmetic display model
module tb_accel_display_sequencer;
  localparam int DW = 10;
  logic          clk = 1'b0, rst_n = 1'b0, sample_valid = 1'b0, auto_en = 1'b0, axis_next = 1'b0;
  logic [DW-1:0] x_data = '0, y_data = '0, z_data = '0;
  logic [23:0]   disp_codes;
  logic          neg, disp_valid, busy;
  logic [1:0]    axis;
  int            checks = 0, failures = 0, ax_m = 0, pulses, n;
  int            shadow[3] = '{0, 0, 0};

  accel_display_sequencer #(.DATA_W(DW), .DWELL_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .x_data(x_data), .y_data(y_data),
    .z_data(z_data), .auto_en(auto_en), .axis_next(axis_next), .disp_codes(disp_codes),
    .neg(neg), .axis(axis), .disp_valid(disp_valid), .busy(busy));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_code(input int ax, input int v);
    int m = v < 0 ? -v : v;
    logic [23:0] c;
    c[23:20] = 4'(10 + ax);
    c[19:16] = 4'hF;
    c[15:12] = m >= 1000 ? 4'(m / 1000 % 10) : 4'hF;
    c[11:8]  = m >= 100 ? 4'(m / 100 % 10) : 4'hF;
    c[7:4]   = m >= 10 ? 4'(m / 10 % 10) : 4'hF;
    c[3:0]   = 4'(m % 10);
    return c;
  endfunction

  task automatic wait_commit(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!disp_valid && cyc < 300);
    chk("disp_valid_seen", 32'(disp_valid), 32'd1);
  endtask

  task automatic expect_out(input string tag, input int lat);
    int c;
    wait_commit(c);
    chk({tag, "_latency"}, 32'(c), 32'(lat));
    chk({tag, "_codes"}, 32'(disp_codes), 32'(exp_code(ax_m, shadow[ax_m])));
    chk({tag, "_neg"}, 32'(neg), 32'(shadow[ax_m] < 0));
    chk({tag, "_axis"}, 32'(axis), 32'(ax_m));
    tick();
    chk({tag, "_pulse_end"}, 32'(disp_valid), 32'd0);
  endtask

  task automatic load_vals(input int x, input int y, input int z);
    x_data = DW'(x);
    y_data = DW'(y);
    z_data = DW'(z);
    shadow = '{x, y, z};
    sample_valid = 1'b1;
  endtask

  task automatic send(input int x, input int y, input int z);
    load_vals(x, y, z);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic step;
    axis_next = 1'b1;
    ax_m = (ax_m + 1) % 3;
    tick();
    axis_next = 1'b0;
  endtask

  task automatic count_pulses(input int cyc, output int p);
    p = 0;
    repeat (cyc) begin
      tick();
      if (disp_valid) p++;
    end
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    count_pulses(100, pulses);
    chk("idle_pulses", 32'(pulses), 32'd0);
    chk("reset_codes", 32'(disp_codes), 32'hFFFFFF);
    chk("reset_neg", 32'(neg), 32'd0);
    chk("reset_axis", 32'(axis), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    send(123, 0, 0);
    expect_out("x_pos123", 13);
    send(-512, 0, 0);
    expect_out("x_min", 13);
    send(0, 7, -45);
    expect_out("x_zero", 13);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("axis_step", 13);
      repeat (6) tick();
    end
    for (int i = 0; i < 16; i++) begin
      int r = $urandom_range(0, 2);
      if (r != 1) load_vals($urandom_range(0, 1023) - 512, $urandom_range(0, 1023) - 512,
                            $urandom_range(0, 1023) - 512);
      if (r != 0) begin
        axis_next = 1'b1;
        ax_m = (ax_m + 1) % 3;
      end
      tick();
      sample_valid = 1'b0;
      axis_next = 1'b0;
      expect_out("random", 13);
      count_pulses(20, pulses);
      chk("random_single_conv", 32'(pulses), 32'd0);
    end
    send(1, 1, 1);
    repeat (4) tick();
    send(99, 99, 99);
    count_pulses(60, pulses);
    chk("b2b_pulses", 32'(pulses), 32'd2);
    chk("b2b_codes", 32'(disp_codes), 32'(exp_code(ax_m, 99)));
    send(5, 5, 5);
    repeat (4) tick();
    chk("conv_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_codes", 32'(disp_codes), 32'hFFFFFF);
    chk("midrst_neg", 32'(neg), 32'd0);
    chk("midrst_axis", 32'(axis), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(disp_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    ax_m = 0;
    count_pulses(30, pulses);
    chk("midrst_discard", 32'(pulses), 32'd0);
    send(5, -6, 7);
    expect_out("auto_prep", 13);
    auto_en = 1'b1;
    ax_m = 1;
    expect_out("auto_first", 113);
    for (int i = 0; i < 2; i++) begin
      ax_m = (ax_m + 1) % 3;
      expect_out("auto_dwell", 99);
    end
    repeat (35) tick();
    step();
    expect_out("auto_manual", 13);
    ax_m = (ax_m + 1) % 3;
    expect_out("auto_restart", 99);
    auto_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/accel_display_sequencer.md
# accel_display_sequencer

Sequences the accelerometer readout onto the six-digit seven-segment bank. Holds the latest X/Y/Z sample, selects one axis at a time (auto-rotating or button-stepped) and converts the signed value to sign plus BCD magnitude with an iterative double-dabble. Drives six 4-bit digit codes, one to each `seg7` decoder: codes 0–9 are digits, 10/11/12 are the axis letters X/Y/Z, and 15 is blank.

## Interface
- `DATA_W`, 10: sample width, two's complement; legal range 4..13, so |min| ≤ 4096 fits in 4 digits.
- `DWELL_CYCLES`, 50_000_000: clock cycles per axis in auto mode (1 s at 50 MHz); ≥ DATA_W+4.
- `clk`  in  1  single clock; everything is synchronous to its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `sample_valid`  in  1  one-cycle strobe: x/y/z_data valid.
- `x_data`, `y_data`, `z_data`  in  DATA_W each  signed samples.
- `auto_en`  in  1  1 = rotate axis every DWELL_CYCLES.
- `axis_next`  in  1  one-cycle pulse (debounced upstream): step to the next axis.
- `disp_codes`  out  24  [23:20]=HEX5 … [3:0]=HEX0 digit codes.
- `neg`  out  1  displayed value is negative (drives an LED; `seg7` has no minus glyph).
- `axis`  out  2  displayed axis: 0=X, 1=Y, 2=Z.
- `disp_valid`  out  1  one-cycle pulse when the outputs update.
- `busy`  out  1  high in LOAD/CONV/COMMIT.

## Operation
- **Shadow capture:** on `sample_valid`=1 in any state, load all three samples into shadow registers and set `pend`.
- **Axis select (`sel`):**
  - `axis_next`, or a dwell expiry when `auto_en`=1, advances `sel` X→Y→Z→X (value 2 wraps to 0), sets `pend` and clears the dwell counter.
  - The dwell counter runs only while `auto_en`=1 and holds at 0 otherwise.
  - `axis_next` is honoured in both modes. If it coincides with a dwell expiry, `sel` advances once.
- **FSM states:**
  - IDLE: go to LOAD if `pend`=1.
  - LOAD (1 cycle): take shadow[`sel`]; set `neg_r` = MSB and `mag` = |value| in DATA_W unsigned bits (−2^(DATA_W−1) → 2^(DATA_W−1)); clear BCD; set `cnt`=DATA_W; clear `pend`; latch `sel` into `axis_r`. A `pend` set in the same cycle wins over the clear, which forces another conversion.
  - CONV (DATA_W cycles): add 3 to each BCD nibble ≥5, then shift {bcd,mag} left by 1; decrement `cnt`; go to COMMIT when `cnt` reaches 1.
  - COMMIT (1 cycle): register the outputs, pulse `disp_valid`, return to IDLE.
- **Digit codes written at COMMIT:**
  - HEX5 = 10 + `axis_r`.
  - HEX4 = 15 (blank).
  - HEX3..HEX1 = BCD digit, or 15 if that digit and every higher one are zero (leading-zero blanking).
  - HEX0 = units digit, always shown.
- Until the first commit after reset the display stays blank.
- `disp_codes`, `neg` and `axis` change only at COMMIT.

## Timing
- **Reset values:** `disp_codes`=24'hFFFFFF, `neg`=0, `axis`=0, `disp_valid`=0, `busy`=0, `sel`=X, shadows=0, `pend`=0, dwell counter=0, FSM=IDLE.
- **Latency:** edge t captures `sample_valid` with FSM in IDLE. LOAD is entered at t+1, CONV at t+2, COMMIT at t+DATA_W+2. New outputs and `disp_valid` are visible after edge t+DATA_W+3, which is 13 cycles for DATA_W=10.
- **`busy`:** high from the LOAD edge until the COMMIT→IDLE edge.
- **Requests while busy:** samples and axis steps arriving during LOAD/CONV/COMMIT are not lost. They leave `pend`=1, and one extra conversion runs using the latest shadow and `sel`.
- A sample and an axis step arriving together in IDLE are serviced by a single conversion.
- **Reset mid-operation:** `rst_n` low in any state immediately forces all reset values. The partial conversion is discarded and the display blanks.

## Test plan
- Reset held then released, no stimulus for 100 cycles → `disp_codes`=24'hFFFFFF, `neg`=0, `axis`=0, `disp_valid` never pulses.
- auto_en=0, `sample_valid` with x=+123 → exactly 13 cycles later `disp_valid`=1, `disp_codes`=24'hAFF123, `neg`=0.
- x=−512 (10'h200) → 24'hAFF512 with `neg`=1; then x=0 → 24'hAFFFF0 with `neg`=0.
- y=7, z=−45 stored, three `axis_next` pulses spaced 20 cycles apart:
  - first → 24'hBFFFF7, `neg`=0;
  - second → 24'hCFFF45, `neg`=1;
  - third → back to X, `axis`=0.
- DWELL_CYCLES=100, auto_en=1 → `axis` steps 0→1→2→0 with `disp_valid` every 100 cycles. An `axis_next` pulse at cycle 50 advances immediately and restarts the dwell count.
- Back-to-back transactions:
  - second `sample_valid` (x=99) 5 cycles after the first (x=1) → two `disp_valid` pulses, final code 24'hAFFF99;
  - `rst_n` low during CONV → all outputs return to reset values.
